// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: digit count, segment
// encodings (active-low, g..a) and the blank pattern.
package seg7_pkg;

    localparam int unsigned DIGITS   = 4;
    localparam int unsigned NIBBLE_W = 4;
    localparam int unsigned SEG_W    = 7;
    localparam int unsigned CATH_W   = 8;

    localparam logic [CATH_W-1:0] SEG_BLANK = 8'hFF;

    localparam logic [SEG_W-1:0] SEG_HEX_0 = 7'h40;
    localparam logic [SEG_W-1:0] SEG_HEX_1 = 7'h79;
    localparam logic [SEG_W-1:0] SEG_HEX_2 = 7'h24;
    localparam logic [SEG_W-1:0] SEG_HEX_3 = 7'h30;
    localparam logic [SEG_W-1:0] SEG_HEX_4 = 7'h19;
    localparam logic [SEG_W-1:0] SEG_HEX_5 = 7'h12;
    localparam logic [SEG_W-1:0] SEG_HEX_6 = 7'h02;
    localparam logic [SEG_W-1:0] SEG_HEX_7 = 7'h78;
    localparam logic [SEG_W-1:0] SEG_HEX_8 = 7'h00;
    localparam logic [SEG_W-1:0] SEG_HEX_9 = 7'h10;
    localparam logic [SEG_W-1:0] SEG_HEX_A = 7'h08;
    localparam logic [SEG_W-1:0] SEG_HEX_B = 7'h03;
    localparam logic [SEG_W-1:0] SEG_HEX_C = 7'h46;
    localparam logic [SEG_W-1:0] SEG_HEX_D = 7'h21;
    localparam logic [SEG_W-1:0] SEG_HEX_E = 7'h06;
    localparam logic [SEG_W-1:0] SEG_HEX_F = 7'h0E;

    // One displayable frame: a nibble and a decimal-point bit per digit.
    typedef struct packed {
        logic [DIGITS-1:0]          dp;
        logic [DIGITS*NIBBLE_W-1:0] value;
    } disp_word_t;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment pattern (g..a).
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [NIBBLE_W-1:0] i_nibble,
    output logic [SEG_W-1:0]    o_seg_n_c
);

    always_comb begin
        o_seg_n_c = SEG_HEX_0;
        case (i_nibble)
            4'h0: o_seg_n_c = SEG_HEX_0;
            4'h1: o_seg_n_c = SEG_HEX_1;
            4'h2: o_seg_n_c = SEG_HEX_2;
            4'h3: o_seg_n_c = SEG_HEX_3;
            4'h4: o_seg_n_c = SEG_HEX_4;
            4'h5: o_seg_n_c = SEG_HEX_5;
            4'h6: o_seg_n_c = SEG_HEX_6;
            4'h7: o_seg_n_c = SEG_HEX_7;
            4'h8: o_seg_n_c = SEG_HEX_8;
            4'h9: o_seg_n_c = SEG_HEX_9;
            4'hA: o_seg_n_c = SEG_HEX_A;
            4'hB: o_seg_n_c = SEG_HEX_B;
            4'hC: o_seg_n_c = SEG_HEX_C;
            4'hD: o_seg_n_c = SEG_HEX_D;
            4'hE: o_seg_n_c = SEG_HEX_E;
            4'hF: o_seg_n_c = SEG_HEX_F;
            default: o_seg_n_c = SEG_HEX_0;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed 4-digit seven-segment driver: prescaled digit scan, frame-
// synchronous double-buffered value, optional leading-zero blanking.
module seven_seg_scan_driver #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned DIGITS      = seg7_pkg::DIGITS
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [seg7_pkg::NIBBLE_W*DIGITS-1:0] value_in,
    input  logic [DIGITS-1:0]                    dp_in,
    input  logic                                 load,
    input  logic                                 blank_lz,
    output logic [DIGITS-1:0]                    anode,
    output logic [seg7_pkg::CATH_W-1:0]          cathode,
    output logic                                 frame_done
);

    import seg7_pkg::*;

    localparam int unsigned PRESC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(DIGITS - 1);

    logic [PRESC_W-1:0]  r_presc;
    logic [IDX_W-1:0]    r_idx;
    disp_word_t          r_pending;
    disp_word_t          r_active;
    logic [DIGITS-1:0]   r_anode;
    logic [CATH_W-1:0]   r_cathode;
    logic                r_frame_done;

    logic                w_tick;
    logic                w_boundary;
    disp_word_t          w_load_word;
    logic [NIBBLE_W-1:0] w_nibble;
    logic [SEG_W-1:0]    w_seg_n;
    logic [IDX_W-1:0]    w_msd;
    logic                w_blank;

    assign w_tick      = (r_presc == PRESC_LAST);
    assign w_boundary  = w_tick && (r_idx == IDX_LAST);
    assign w_load_word = {dp_in, value_in};
    assign w_nibble    = r_active.value[r_idx*NIBBLE_W +: NIBBLE_W];

    hex_to_seg7 u_hex_to_seg7 (
        .i_nibble  (w_nibble),
        .o_seg_n_c (w_seg_n)
    );

    // Highest nonzero digit; digit0 when the whole value is zero.
    always_comb begin
        w_msd = '0;
        for (int unsigned i = 1; i < DIGITS; i++) begin
            if (r_active.value[i*NIBBLE_W +: NIBBLE_W] != '0) begin
                w_msd = IDX_W'(i);
            end
        end
    end

    assign w_blank = blank_lz && (r_idx > w_msd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
            r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // A load landing on the boundary bypasses pending so it shows next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
            r_active  <= '0;
        end else begin
            if (load) begin
                r_pending <= w_load_word;
            end
            if (w_boundary) begin
                r_active <= load ? w_load_word : r_pending;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_anode      <= '1;
            r_cathode    <= SEG_BLANK;
            r_frame_done <= 1'b0;
        end else begin
            r_anode      <= ~(DIGITS'(1) << r_idx);
            r_cathode    <= w_blank ? SEG_BLANK : {~r_active.dp[r_idx], w_seg_n};
            r_frame_done <= w_boundary;
        end
    end

    assign anode      = r_anode;
    assign cathode    = r_cathode;
    assign frame_done = r_frame_done;

endmodule
